// File: rtl/rsa_modexp_ctrl.sv
// Scheduler for left-to-right square-and-multiply modular exponentiation.
// Issues one Montgomery-multiplier operation at a time and scans the exponent MSB-first.
module rsa_modexp_ctrl #(
   parameter int EXP_W = 2048,
   parameter int IDX_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IDX_W:0]   exp_len,
   output logic [IDX_W-1:0] exp_idx,
   input  logic             exp_bit,
   output logic             mm_start,
   output logic [1:0]       mm_op,
   input  logic             mm_done,
   output logic             acc_init,
   output logic             busy,
   output logic             done,
   output logic [12:0]      op_cnt
);

   localparam logic [1:0] OP_TO   = 2'b00;
   localparam logic [1:0] OP_SQR  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_FROM = 2'b11;

   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(EXP_W);
   localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

   // The bit-scan decision is taken in WAIT on the mm_done edge itself, so the
   // next operation launches the following cycle (single-cycle turnaround).
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      WAIT  = 3'd2,
      FWAIT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t         state;
   logic [IDX_W:0] bits_left;
   logic [IDX_W:0] scan_n;
   logic [12:0]    op_cnt_next;

   // After TO_MONT the full length is still pending; after a finished bit it shrinks by one.
   always_comb begin
      scan_n      = (mm_op == OP_TO) ? bits_left : bits_left - ONE;
      op_cnt_next = (op_cnt == '1) ? op_cnt : op_cnt + 13'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bits_left <= '0;
         exp_idx   <= '0;
         mm_start  <= 1'b0;
         mm_op     <= OP_TO;
         acc_init  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         op_cnt    <= '0;
      end else begin
         mm_start <= 1'b0;
         acc_init <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bits_left <= (exp_len > LEN_MAX) ? LEN_MAX : exp_len;
                  op_cnt    <= '0;
                  acc_init  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= INIT;
               end
            end
            INIT: begin
               mm_start <= 1'b1;
               mm_op    <= OP_TO;
               op_cnt   <= op_cnt_next;
               state    <= WAIT;
            end
            WAIT: begin
               if (mm_done) begin
                  mm_start <= 1'b1;
                  op_cnt   <= op_cnt_next;
                  // exp_idx is unchanged since the square, so exp_bit is the current bit
                  if (mm_op == OP_SQR && exp_bit) begin
                     mm_op <= OP_MUL;
                  end else if (scan_n == '0) begin
                     bits_left <= '0;
                     mm_op     <= OP_FROM;
                     state     <= FWAIT;
                  end else begin
                     bits_left <= scan_n;
                     exp_idx   <= IDX_W'(scan_n - ONE);
                     mm_op     <= OP_SQR;
                  end
               end
            end
            FWAIT: begin
               if (mm_done) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl: a behavioural MM answers each mm_start,
// a negedge monitor pops expected mm_op / op_cnt values pushed by the driver.
module tb_rsa_modexp_ctrl;

   localparam int EXP_W = 2048;
   localparam int IDX_W = 11;
   localparam logic [1:0] TO = 2'b00, SQ = 2'b01, MU = 2'b10, FR = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [IDX_W:0]   exp_len = '0;
   logic [IDX_W-1:0] exp_idx;
   logic             exp_bit;
   logic             mm_start;
   logic [1:0]       mm_op;
   logic             mm_done;
   logic             acc_init;
   logic             busy;
   logic             done;
   logic [12:0]      op_cnt;

   logic done_model = 1'b0;
   logic done_spur  = 1'b0;
   int   mm_lat     = 3;
   logic exp_mem [EXP_W];

   logic [1:0]  exp_q[$];
   logic [12:0] cnt_q[$];
   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int outstanding = 0;

   assign exp_bit = exp_mem[exp_idx];
   assign mm_done = done_model | done_spur;

   rsa_modexp_ctrl #(.EXP_W(EXP_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_len(exp_len),
      .exp_idx(exp_idx), .exp_bit(exp_bit), .mm_start(mm_start), .mm_op(mm_op),
      .mm_done(mm_done), .acc_init(acc_init), .busy(busy), .done(done), .op_cnt(op_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // behavioural multiplier: mm_done mm_lat cycles after each mm_start
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && mm_start) begin
            repeat (mm_lat) @(posedge clk);
            #1 done_model = 1'b1;
            @(posedge clk);
            #1 done_model = 1'b0;
         end
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding = 0;
      end else begin
         if (mm_start) begin
            check("no_overlap", outstanding, 0);
            check("busy_during_op", {31'd0, busy}, 1);
            if (exp_q.size() == 0) check("extra_mm_start", {30'd0, mm_op}, 32'hFFFF_FFFF);
            else check("mm_op", {30'd0, mm_op}, {30'd0, exp_q.pop_front()});
         end
         if (mm_done) outstanding = 0;
         if (mm_start) outstanding = 1;
         if (done) begin
            done_cnt++;
            check("busy_at_done", {31'd0, busy}, 0);
            check("ops_left_at_done", exp_q.size(), 0);
            if (cnt_q.size() == 0) check("extra_done", {19'd0, op_cnt}, 32'hFFFF_FFFF);
            else check("op_cnt", {19'd0, op_cnt}, {19'd0, cnt_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic set_exp(input int len, input logic [31:0] pattern, input logic fill);
      for (int i = 0; i < EXP_W; i++) exp_mem[i] = (i < 32) ? pattern[i] : fill;
      exp_len = (IDX_W+1)'(len);
   endtask

   task automatic push_1011();
      logic [1:0] seq [9];
      seq = '{TO, SQ, MU, SQ, SQ, MU, SQ, MU, FR};
      for (int i = 0; i < 9; i++) exp_q.push_back(seq[i]);
      cnt_q.push_back(13'd9);
      exp_done++;
   endtask

   task automatic start_run();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1;
      check("acc_init_pulse", {31'd0, acc_init}, 1);
      check("busy_after_start", {31'd0, busy}, 1);
      check("no_early_mm_start", {31'd0, mm_start}, 0);
      @(negedge clk);
      #1;
      check("mm_start_latency", {31'd0, mm_start}, 1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt < exp_done && n < budget) begin
         @(negedge clk);
         #1 n++;
      end
      check("done_timeout", done_cnt, exp_done);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mm_start"}, {31'd0, mm_start}, 0);
      check({tag, "_acc_init"}, {31'd0, acc_init}, 0);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_mm_op"}, {30'd0, mm_op}, 0);
      check({tag, "_exp_idx"}, {21'd0, exp_idx}, 0);
      check({tag, "_op_cnt"}, {19'd0, op_cnt}, 0);
   endtask

   initial begin
      set_exp(0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;

      // exponent 1011, 3-cycle MM
      mm_lat = 3;
      set_exp(4, 32'b1011, 1'b0);
      push_1011();
      start_run();
      wait_done(200);

      // zero-length exponent: only TO_MONT then FROM_MONT
      set_exp(0, 32'd0, 1'b0);
      exp_q.push_back(TO); exp_q.push_back(FR);
      cnt_q.push_back(13'd2);
      exp_done++;
      start_run();
      wait_done(100);

      // eight zero bits: squares only
      set_exp(8, 32'd0, 1'b0);
      exp_q.push_back(TO);
      for (int i = 0; i < 8; i++) exp_q.push_back(SQ);
      exp_q.push_back(FR);
      cnt_q.push_back(13'd10);
      exp_done++;
      start_run();
      wait_done(300);

      // start during WAIT and spurious mm_done in IDLE are both ignored
      set_exp(4, 32'b1011, 1'b0);
      push_1011();
      start_run();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200);
      repeat (3) @(posedge clk);
      #1 done_spur = 1'b1;
      @(posedge clk);
      #1 done_spur = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("idle_after_spur_busy", {31'd0, busy}, 0);
      check("op_cnt_held", {19'd0, op_cnt}, 9);
      check("done_count_spur", done_cnt, exp_done);

      // reset mid-WAIT, late mm_done ignored, then a clean rerun
      push_1011();
      exp_done--;
      start_run();
      #1 rst_n = 1'b0;
      exp_q.delete();
      cnt_q.delete();
      @(posedge clk);
      #1 check_reset_outputs("midreset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      check("late_done_no_start", outstanding, 0);
      check("late_done_busy", {31'd0, busy}, 0);
      check("late_done_op_cnt", {19'd0, op_cnt}, 0);
      push_1011();
      start_run();
      wait_done(200);

      // full-width all-ones exponent, back-to-back MM
      mm_lat = 1;
      set_exp(EXP_W, 32'hFFFF_FFFF, 1'b1);
      exp_q.push_back(TO);
      for (int i = 0; i < EXP_W; i++) begin
         exp_q.push_back(SQ);
         exp_q.push_back(MU);
      end
      exp_q.push_back(FR);
      cnt_q.push_back(13'd4098);
      exp_done++;
      start_run();
      wait_done(10000);

      // over-length request is clamped to EXP_W
      set_exp(3000, 32'd0, 1'b0);
      exp_q.push_back(TO);
      for (int i = 0; i < EXP_W; i++) exp_q.push_back(SQ);
      exp_q.push_back(FR);
      cnt_q.push_back(13'd2050);
      exp_done++;
      start_run();
      wait_done(6000);

      repeat (3) @(negedge clk);
      check("final_done_count", done_cnt, exp_done);
      check("final_queue_empty", exp_q.size() + cnt_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
